// File: rtl/aes_pkg.sv
// Shared AES-128 decipher definitions: round count, FSM encoding and GF(2^8)
// arithmetic helpers used by the datapath and the inverse S-box.
package aes_pkg;

  localparam logic [3:0] AES128_ROUNDS = 4'ha;

  typedef enum logic [1:0] {
    STATE_IDLE = 2'b00,
    STATE_DEC  = 2'b01
  } state_e;

  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = gf_xtime(sh);
    end
    return acc;
  endfunction

  // Multiplicative inverse as x^254 via an addition chain; maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    return gf_mul(x252, x2);
  endfunction

  // Byte k lives at [127-8k -: 8]; k = 4*col + row.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^
                         gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^
                         gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^
                         gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^
                         gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Sixteen parallel AES inverse S-boxes: inverse affine map, then GF(2^8) inverse.
module aes_inv_sbox
  import aes_pkg::*;
(
  input  logic [127:0] data_i,
  output logic [127:0] data_o
);

  function automatic logic [7:0] inv_affine(input logic [7:0] b);
    return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
  endfunction

  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign data_o[8*i +: 8] = gf_inv(inv_affine(data_i[8*i +: 8]));
  end

endmodule

// File: rtl/my_aes_decipher.sv
// Iterative AES-128 decipher: one inverse round per clock using a preloaded
// forward-order round-key memory; one block every 11 cycles.
module my_aes_decipher #(
  parameter logic [3:0] AES128_ROUNDS = aes_pkg::AES128_ROUNDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         next,
  input  logic [3:0]   init_round,
  input  logic [127:0] init_roundkey,
  input  logic         init_roundkey_valid,
  input  logic [127:0] block,
  output logic [127:0] plainblock,
  output logic         result_valid,
  output logic         ready
);
  import aes_pkg::*;

  localparam int unsigned NumKeys = int'(AES128_ROUNDS) + 1;

  state_e       state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] block_q, block_d;
  logic         result_valid_q, result_valid_d;
  logic [127:0] key_mem_q [NumKeys];
  logic [127:0] key_mem_d [NumKeys];

  logic [127:0] sbox_out;
  logic [127:0] add_rk;

  aes_inv_sbox u_inv_sbox (
    .data_i (inv_shift_rows(block_q)),
    .data_o (sbox_out)
  );

  assign add_rk = sbox_out ^ key_mem_q[round_q];

  always_comb begin
    state_d        = state_q;
    round_d        = round_q;
    block_d        = block_q;
    result_valid_d = 1'b0;
    key_mem_d      = key_mem_q;
    unique case (state_q)
      STATE_IDLE: begin
        if (init_roundkey_valid && (init_round <= AES128_ROUNDS)) begin
          key_mem_d[init_round] = init_roundkey;
        end
        // Initial whitening reads the pre-write key memory.
        if (next) begin
          block_d = block ^ key_mem_q[AES128_ROUNDS];
          round_d = AES128_ROUNDS - 4'd1;
          state_d = STATE_DEC;
        end
      end
      STATE_DEC: begin
        if (round_q == 4'd0) begin
          block_d        = add_rk;
          result_valid_d = 1'b1;
          state_d        = STATE_IDLE;
        end else begin
          block_d = inv_mix_columns(add_rk);
          round_d = round_q - 4'd1;
        end
      end
      default: state_d = STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= STATE_IDLE;
      round_q        <= 4'd0;
      block_q        <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      round_q        <= round_d;
      block_q        <= block_d;
      result_valid_q <= result_valid_d;
    end
  end

  // Round keys deliberately survive reset.
  always_ff @(posedge clk) begin
    key_mem_q <= key_mem_d;
  end

  assign plainblock   = block_q;
  assign result_valid = result_valid_q;
  assign ready        = (state_q == STATE_IDLE);

endmodule

// File: tb/tb_my_aes_decipher.sv
// Self-checking bench for my_aes_decipher: byte-level AES reference model with
// its own key expansion, per-cycle compare, and FIPS-197 literal vectors.
module tb_my_aes_decipher;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_K10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_K10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         next = 1'b0;
  logic [3:0]   init_round = 4'd0;
  logic [127:0] init_roundkey = '0;
  logic         init_roundkey_valid = 1'b0;
  logic [127:0] block = '0;
  logic [127:0] plainblock;
  logic         result_valid;
  logic         ready;

  my_aes_decipher dut (
    .clk                 (clk),
    .rst                 (rst),
    .next                (next),
    .init_round          (init_round),
    .init_roundkey       (init_roundkey),
    .init_roundkey_valid (init_roundkey_valid),
    .block               (block),
    .plainblock          (plainblock),
    .result_valid        (result_valid),
    .ready               (ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  logic chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference math ----------------
  logic [7:0] sbox_t  [256];
  logic [7:0] isbox_t [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // Forward S-box from a brute-force inverse search plus the affine map.
  task automatic build_tables();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox_t[x]  = s;
      isbox_t[s] = 8'(x);
    end
  endtask

  task automatic expand_key(input logic [127:0] key, output logic [127:0] rk [11]);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t = t ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] model_decrypt(input logic [127:0] ct,
                                                 input logic [127:0] k [11]);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   cof [4];
    logic [7:0]   acc;
    logic [127:0] rk, out;
    cof[0] = 8'h0e; cof[1] = 8'h0b; cof[2] = 8'h0d; cof[3] = 8'h09;
    rk = k[10];
    for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ rk[127-8*i -: 8];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      rk = k[rnd];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[4*c+r] = isbox_t[s[4*((c+4-r)%4)+r]] ^ rk[127-8*(4*c+r) -: 8];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) begin
          if (rnd > 0) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) acc = acc ^ gmul(cof[(j-r+4)%4], t[4*c+j]);
            s[4*c+r] = acc;
          end else begin
            s[4*c+r] = t[4*c+r];
          end
        end
    end
    for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
    return out;
  endfunction

  // ---------------- cycle-level model ----------------
  logic [127:0] m_keys [11];
  int           m_cnt    = 0;
  logic         m_valid  = 1'b0;
  logic [127:0] m_plain  = '0;
  logic [127:0] m_result = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt   <= 0;
      m_valid <= 1'b0;
      m_plain <= '0;
    end else begin
      m_valid <= 1'b0;
      if (m_cnt == 0) begin
        if (init_roundkey_valid && init_round <= 4'd10) m_keys[init_round] <= init_roundkey;
        if (next) begin
          m_cnt    <= 10;
          m_result <= model_decrypt(block, m_keys);
        end
      end else begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_valid <= 1'b1;
          m_plain <= m_result;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", 128'(ready), 128'(m_cnt == 0));
      check("result_valid", 128'(result_valid), 128'(m_valid));
      if (m_cnt == 0) check("plainblock", plainblock, m_plain);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic load_keys(input logic [127:0] k [11]);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      init_round          = 4'(i);
      init_roundkey       = k[i];
      init_roundkey_valid = 1'b1;
    end
    @(negedge clk);
    init_roundkey_valid = 1'b0;
  endtask

  task automatic start_op(input logic [127:0] b, input logic wr,
                          input logic [3:0] wr_idx, input logic [127:0] wr_key);
    @(negedge clk);
    next                = 1'b1;
    block               = b;
    init_roundkey_valid = wr;
    init_round          = wr_idx;
    init_roundkey       = wr_key;
    @(posedge clk);
    #1;
    acc_cyc             = cyc;
    next                = 1'b0;
    init_roundkey_valid = 1'b0;
  endtask

  task automatic wait_result(input string name, output logic [127:0] pt, output int lat);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (result_valid) seen = 1'b1;
    end
    if (!seen) check({name, "_timeout"}, 128'd0, 128'd1);
    pt  = plainblock;
    lat = cyc - acc_cyc;
  endtask

  task automatic run_c1(input string name);
    logic [127:0] pt;
    int           lat;
    start_op(C1_CT, 1'b0, 4'd0, '0);
    wait_result(name, pt, lat);
    check({name, "_latency"}, 128'(lat), 128'd10);
    check({name, "_pt"}, pt, C1_PT);
  endtask

  logic [127:0] rk_c1 [11];
  logic [127:0] rk_b  [11];

  initial begin
    logic [127:0] pt;
    int           lat, c1, c2, low_cnt, rv_cnt;

    build_tables();
    expand_key(C1_KEY, rk_c1);
    expand_key(B_KEY, rk_b);
    check("model_c1_k10", rk_c1[10], C1_K10);
    check("model_b_k10", rk_b[10], B_K10);
    check("model_c1_pt", model_decrypt(C1_CT, rk_c1), C1_PT);
    check("model_b_pt", model_decrypt(B_CT, rk_b), B_PT);

    // Asynchronous reset, checked before any clock edge.
    #1 rst = 1'b0;
    #1;
    check("rst_ready", 128'(ready), 128'd1);
    check("rst_valid", 128'(result_valid), 128'd0);
    check("rst_plain", plainblock, 128'd0);
    repeat (2) @(negedge clk);
    rst    = 1'b1;
    chk_en = 1'b1;

    // FIPS-197 App. B, then C.1.
    load_keys(rk_b);
    start_op(B_CT, 1'b0, 4'd0, '0);
    wait_result("appb", pt, lat);
    check("appb_latency", 128'(lat), 128'd10);
    check("appb_pt", pt, B_PT);
    load_keys(rk_c1);
    run_c1("c1");

    // Key write on the accepting edge: old slot 10 whitens, new value lands.
    start_op(C1_CT, 1'b1, 4'd10, B_K10);
    wait_result("wr_accept", pt, lat);
    check("wr_accept_pt", pt, C1_PT);
    start_op(C1_CT, 1'b0, 4'd0, '0);
    wait_result("wr_newkey", pt, lat);
    check("wr_newkey_pt", pt, model_decrypt(C1_CT, {rk_c1[0], rk_c1[1], rk_c1[2], rk_c1[3],
          rk_c1[4], rk_c1[5], rk_c1[6], rk_c1[7], rk_c1[8], rk_c1[9], B_K10}));
    @(negedge clk);
    init_round = 4'd10; init_roundkey = C1_K10; init_roundkey_valid = 1'b1;
    @(negedge clk);
    init_roundkey_valid = 1'b0;

    // Back-to-back with next held high.
    @(negedge clk);
    next  = 1'b1;
    block = C1_CT;
    @(posedge clk);
    #1;
    block = 128'hffeeddccbbaa99887766554433221100;
    c1 = -1;
    for (int i = 0; i < 20 && c1 < 0; i++) begin
      @(negedge clk);
      if (result_valid) c1 = cyc;
    end
    check("b2b_first_seen", 128'(c1 >= 0), 128'd1);
    check("b2b_first_pt", plainblock, C1_PT);
    @(posedge clk);
    #1 next = 1'b0;
    c2 = -1;
    low_cnt = 0;
    for (int i = 0; i < 20 && c2 < 0; i++) begin
      @(negedge clk);
      if (!ready) low_cnt++;
      if (result_valid) c2 = cyc;
    end
    check("b2b_gap", 128'(c2 - c1), 128'd11);
    check("b2b_ready_low", 128'(low_cnt), 128'd10);

    // Next pulses and key writes while busy are ignored.
    start_op(C1_CT, 1'b0, 4'd0, '0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      next = 1'b1; block = {4{$urandom}};
      init_roundkey_valid = 1'b1; init_round = (i % 2 == 0) ? 4'd10 : 4'd3;
      init_roundkey = '1;
    end
    @(negedge clk);
    next = 1'b0; init_roundkey_valid = 1'b0;
    wait_result("busy", pt, lat);
    check("busy_latency", 128'(lat), 128'd10);
    check("busy_pt", pt, C1_PT);
    run_c1("busy_keys");

    // Reset in the middle of an operation.
    start_op(C1_CT, 1'b0, 4'd0, '0);
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_plain", plainblock, 128'd0);
    check("midrst_ready", 128'(ready), 128'd1);
    check("midrst_valid", 128'(result_valid), 128'd0);
    @(negedge clk);
    rst = 1'b1;
    rv_cnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (result_valid) rv_cnt++;
    end
    check("midrst_no_pulse", 128'(rv_cnt), 128'd0);
    run_c1("after_rst");

    // Out-of-range key slots are ignored.
    @(negedge clk);
    init_round = 4'd11; init_roundkey = '1; init_roundkey_valid = 1'b1;
    @(negedge clk);
    init_round = 4'd15;
    @(negedge clk);
    init_roundkey_valid = 1'b0;
    run_c1("oor");

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1);
  end

endmodule
